// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Stall/flush/redirect controller for a 5-stage in-order pipeline.
//            Resolves data-memory stalls, traps, branch redirects, load-use
//            hazards and instruction-fetch stalls in fixed priority order,
//            and counts cycles in which the PC is held.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_busy_i,
  input  logic        dmem_busy_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        id_use_rs1_i,
  input  logic [4:0]  id_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_redirect_i,
  input  logic        trap_req_i,
  output logic        en_pc_o,
  output logic        en_fd_o,
  output logic        en_de_o,
  output logic        en_em_o,
  output logic        en_mw_o,
  output logic        flush_fd_o,
  output logic        flush_de_o,
  output logic        flush_em_o,
  output logic        flush_mw_o,
  output logic [1:0]  pc_sel_o,
  output logic        fetch_kill_o,
  output logic [31:0] stall_cnt_o
);

  // FSM encoding
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DWAIT = 2'd1;
  localparam logic [1:0] ST_KILL  = 2'd2;

  // PC source select encoding
  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  state_q, state_d;
  // Remembers that a fetch kill was still outstanding when a data-memory
  // stall interrupted KILL, so the stale fetch is still dropped afterwards.
  logic        kill_pend_q, kill_pend_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        in_kill;
  logic        load_use;

  // Load-use hazard: EX holds a load whose non-zero destination is read in ID.
  always_comb begin
    load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
               ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

  // Priority resolution of pipeline controls and next-state selection.
  always_comb begin
    en_pc_o      = 1'b1;
    en_fd_o      = 1'b1;
    en_de_o      = 1'b1;
    en_em_o      = 1'b1;
    en_mw_o      = 1'b1;
    flush_fd_o   = 1'b0;
    flush_de_o   = 1'b0;
    flush_em_o   = 1'b0;
    flush_mw_o   = 1'b0;
    pc_sel_o     = PC_SEQ;
    state_d      = state_q;
    kill_pend_d  = kill_pend_q;

    // A kill is live in KILL, or in DWAIT when the stall interrupted a KILL.
    in_kill      = (state_q == ST_KILL) || ((state_q == ST_DWAIT) && kill_pend_q);
    fetch_kill_o = in_kill;

    if (dmem_busy_i) begin
      // Freeze everything up to EX/MEM; MEM/WB receives a bubble. Trap and
      // redirect come from frozen registers and are re-seen after the stall.
      en_pc_o     = 1'b0;
      en_fd_o     = 1'b0;
      en_de_o     = 1'b0;
      en_em_o     = 1'b0;
      flush_mw_o  = 1'b1;
      state_d     = ST_DWAIT;
      kill_pend_d = in_kill;
    end else begin
      kill_pend_d = 1'b0;
      state_d     = ST_RUN;

      if (in_kill) begin
        // Hold the PC and keep bubbling IF/ID until the stale fetch returns;
        // the return cycle itself is still flushed.
        en_pc_o    = 1'b0;
        flush_fd_o = 1'b1;
        if (imem_busy_i) begin
          state_d = ST_KILL;
        end
      end

      if (trap_req_i) begin
        en_pc_o    = 1'b1;
        flush_fd_o = 1'b1;
        flush_de_o = 1'b1;
        flush_em_o = 1'b1;
        pc_sel_o   = PC_TRAP;
        if (imem_busy_i) begin
          state_d = ST_KILL;
        end
      end else if (ex_redirect_i) begin
        en_pc_o    = 1'b1;
        flush_fd_o = 1'b1;
        flush_de_o = 1'b1;
        pc_sel_o   = PC_BR;
        if (imem_busy_i) begin
          state_d = ST_KILL;
        end
      end else if (!in_kill && load_use) begin
        // IF/ID holds only bubbles during a kill, so no hazard can exist there.
        en_pc_o    = 1'b0;
        en_fd_o    = 1'b0;
        flush_de_o = 1'b1;
      end else if (!in_kill && imem_busy_i) begin
        en_pc_o    = 1'b0;
        flush_fd_o = 1'b1;
      end
    end

    // While reset is held every pipeline register is cleared.
    if (!rst_ni) begin
      en_pc_o      = 1'b1;
      en_fd_o      = 1'b1;
      en_de_o      = 1'b1;
      en_em_o      = 1'b1;
      en_mw_o      = 1'b1;
      flush_fd_o   = 1'b1;
      flush_de_o   = 1'b1;
      flush_em_o   = 1'b1;
      flush_mw_o   = 1'b1;
      pc_sel_o     = PC_SEQ;
      fetch_kill_o = 1'b0;
    end
  end

  // Saturating count of PC-hold cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!en_pc_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State, pending-kill and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      kill_pend_q <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed-vector scoreboard bench for pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  typedef struct packed {
    logic [4:0]  en;   // {pc, fd, de, em, mw}
    logic [3:0]  fl;   // {fd, de, em, mw}
    logic [1:0]  sel;
    logic        fk;
    logic [31:0] cnt;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_busy_i = 1'b0;
  logic        dmem_busy_i = 1'b0;
  logic        ex_is_load_i = 1'b0;
  logic [4:0]  ex_rd_i = 5'd0;
  logic        id_use_rs1_i = 1'b0;
  logic [4:0]  id_rs1_i = 5'd0;
  logic        id_use_rs2_i = 1'b0;
  logic [4:0]  id_rs2_i = 5'd0;
  logic        ex_redirect_i = 1'b0;
  logic        trap_req_i = 1'b0;
  logic        en_pc_o, en_fd_o, en_de_o, en_em_o, en_mw_o;
  logic        flush_fd_o, flush_de_o, flush_em_o, flush_mw_o;
  logic [1:0]  pc_sel_o;
  logic        fetch_kill_o;
  logic [31:0] stall_cnt_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  pipe_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_busy_i  (imem_busy_i),
    .dmem_busy_i  (dmem_busy_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_rs1_i     (id_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rs2_i     (id_rs2_i),
    .ex_redirect_i(ex_redirect_i),
    .trap_req_i   (trap_req_i),
    .en_pc_o      (en_pc_o),
    .en_fd_o      (en_fd_o),
    .en_de_o      (en_de_o),
    .en_em_o      (en_em_o),
    .en_mw_o      (en_mw_o),
    .flush_fd_o   (flush_fd_o),
    .flush_de_o   (flush_de_o),
    .flush_em_o   (flush_em_o),
    .flush_mw_o   (flush_mw_o),
    .pc_sel_o     (pc_sel_o),
    .fetch_kill_o (fetch_kill_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // One vector per cycle: drive inputs just after the rising edge and queue
  // the hand-computed response expected before the next rising edge.
  task automatic cyc(input logic r, input logic im, input logic dm,
                     input logic ld, input logic [4:0] rd,
                     input logic u1, input logic [4:0] r1,
                     input logic u2, input logic [4:0] r2,
                     input logic rdir, input logic tr,
                     input logic [4:0] en, input logic [3:0] fl,
                     input logic [1:0] sel, input logic fk,
                     input logic [31:0] cnt);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni        = r;
    imem_busy_i   = im;
    dmem_busy_i   = dm;
    ex_is_load_i  = ld;
    ex_rd_i       = rd;
    id_use_rs1_i  = u1;
    id_rs1_i      = r1;
    id_use_rs2_i  = u2;
    id_rs2_i      = r2;
    ex_redirect_i = rdir;
    trap_req_i    = tr;
    e.en  = en;
    e.fl  = fl;
    e.sel = sel;
    e.fk  = fk;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT response at mid-cycle against the queue head.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {en_pc_o, en_fd_o, en_de_o, en_em_o, en_mw_o,
               flush_fd_o, flush_de_o, flush_em_o, flush_mw_o,
               pc_sel_o, fetch_kill_o, stall_cnt_o};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL vec%0d: got en=%b fl=%b sel=%0d fk=%b cnt=%0d, expected en=%b fl=%b sel=%0d fk=%b cnt=%0d",
                   vec, got.en, got.fl, got.sel, got.fk, got.cnt,
                   e.en, e.fl, e.sel, e.fk, e.cnt);
        end
        vec++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //   rst im dm ld rd    u1 r1    u2 r2    rdr tr  en        fl       sel   fk    cnt
    // Reset held
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b1111, 2'd0, 1'b0, 32'd0);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b1111, 2'd0, 1'b0, 32'd0);
    // Idle after release
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd0);
    // Load-use on rs1, one bubble
    cyc(1, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 5'b00111, 4'b0100, 2'd0, 1'b0, 32'd0);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd1);
    // Load to x0 is no hazard
    cyc(1, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd1);
    // Load-use on rs2
    cyc(1, 0, 0, 1, 5'd7, 0, 5'd7, 1, 5'd7, 0, 0, 5'b00111, 4'b0100, 2'd0, 1'b0, 32'd1);
    // Register mismatch, and matching register without use flag
    cyc(1, 0, 0, 1, 5'd7, 1, 5'd6, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd2);
    cyc(1, 0, 0, 1, 5'd7, 0, 5'd7, 0, 5'd7, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd2);
    // Fetch stall alone
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b0, 32'd2);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd3);
    // Data stall masks a redirect for 3 cycles, redirect taken on the 4th
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b00001, 4'b0001, 2'd0, 1'b0, 32'd3);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b00001, 4'b0001, 2'd0, 1'b0, 32'd4);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b00001, 4'b0001, 2'd0, 1'b0, 32'd5);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b11111, 4'b1100, 2'd1, 1'b0, 32'd6);
    // Trap beats redirect
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 5'b11111, 4'b1110, 2'd2, 1'b0, 32'd6);
    // Redirect during fetch stall enters KILL; imem busy 2 more cycles
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b11111, 4'b1100, 2'd1, 1'b0, 32'd6);
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd6);
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd7);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd8);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd9);
    // Trap while in KILL: taken with en_pc = 1, KILL retained
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b11111, 4'b1100, 2'd1, 1'b0, 32'd9);
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'b11111, 4'b1110, 2'd2, 1'b1, 32'd9);
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd9);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd10);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd11);
    // Data stall interrupting KILL keeps the kill pending
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b11111, 4'b1100, 2'd1, 1'b0, 32'd11);
    cyc(1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b00001, 4'b0001, 2'd0, 1'b1, 32'd11);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd12);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd13);
    // Reset asserted mid-KILL: immediate clear, no kill after release
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b11111, 4'b1100, 2'd1, 1'b0, 32'd13);
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b1, 32'd13);
    cyc(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b1111, 2'd0, 1'b0, 32'd0);
    cyc(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b1111, 2'd0, 1'b0, 32'd0);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd0);
    cyc(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b01111, 4'b1000, 2'd0, 1'b0, 32'd0);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'b11111, 4'b0000, 2'd0, 1'b0, 32'd1);

    repeat (3) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never compared, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
